// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 fetch stage.
//   fetch_state_t : fetch handshake FSM states
//   LC3_RESET_PC  : architectural reset vector
//   lc3_word_t    : 16-bit LC3 machine word
package lc3_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [15:0] LC3_RESET_PC = 16'h3000;

    typedef logic [15:0] lc3_word_t;

endpackage

// File: rtl/lc3_fetch_stage_pc_unit.sv
// PC register with next-PC adder and branch-target select.
// Ports:
//   clock, reset        : stage clock, synchronous active-low reset
//   enable_updatePC     : load a new PC this edge
//   br_taken, taddr     : choose taddr instead of pc+1 when loading
//   pc, npc             : current PC and pc+1 (wraps modulo 2^16)
module lc3_pc_unit
    import lc3_fetch_pkg::*;
#(
    parameter lc3_word_t RESET_PC = LC3_RESET_PC
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_updatePC,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    output logic [15:0] pc,
    output logic [15:0] npc
);

    assign npc = pc + 16'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (enable_updatePC) begin
            pc <= br_taken ? taddr : npc;
        end
    end

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC3 fetch stage: owns the PC, issues instruction-memory reads, waits for
// the memory handshake and latches the returned word into IR.
// Ports:
//   clock, reset                  : stage clock, synchronous active-low reset
//   enable_fetch                  : controller permits a new read
//   enable_updatePC, br_taken,
//   taddr                         : PC update control (see lc3_pc_unit)
//   imem_rdy, imem_dout           : memory response handshake and data
//   pc, npc                       : current PC (memory address) and pc+1
//   instrmem_rd                   : read strobe to instruction memory
//   ir, ir_valid                  : accepted instruction and 1-cycle pulse
//   fetch_busy                    : a request is outstanding (WAIT/FLUSH)
//   fetch_err                     : sticky watchdog flag
module lc3_fetch_stage
    import lc3_fetch_pkg::*;
#(
    parameter lc3_word_t RESET_PC   = LC3_RESET_PC,
    parameter int        WAIT_LIMIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        enable_updatePC,
    input  logic [15:0] taddr,
    input  logic        br_taken,
    input  logic        imem_rdy,
    input  logic [15:0] imem_dout,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic        instrmem_rd,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        fetch_busy,
    output logic        fetch_err
);

    // Watchdog threshold expressed against the pre-increment count, so the
    // flag sets on the edge that ends the WAIT_LIMIT-th unanswered cycle.
    localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

    fetch_state_t state, state_next;
    logic [7:0]   wait_cnt;
    logic         accept;

    lc3_pc_unit #(
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clock           (clock),
        .reset           (reset),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .pc              (pc),
        .npc             (npc)
    );

    always_comb begin
        state_next  = state;
        instrmem_rd = 1'b0;
        fetch_busy  = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                instrmem_rd = enable_fetch;
                if (enable_fetch) begin
                    if (imem_rdy) accept = 1'b1;
                    else          state_next = WAIT;
                end
            end
            WAIT: begin
                // Strobe held until the memory answers, even if enable_fetch drops.
                instrmem_rd = 1'b1;
                fetch_busy  = 1'b1;
                if (imem_rdy) begin
                    // Data belongs to the address already presented, so it is
                    // kept even when the PC moves on this same edge.
                    accept     = 1'b1;
                    state_next = IDLE;
                end else if (enable_updatePC) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                // Outstanding response belongs to a stale PC: drain and drop it.
                fetch_busy = 1'b1;
                if (imem_rdy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            fetch_err <= 1'b0;
            ir        <= 16'h0000;
            ir_valid  <= 1'b0;
        end else begin
            state    <= state_next;
            ir_valid <= accept;
            if (accept) ir <= imem_dout;

            // Counter spans WAIT and FLUSH; only IDLE clears it.
            if (state == IDLE) begin
                wait_cnt <= 8'd0;
            end else if (!imem_rdy) begin
                if (wait_cnt >= LIMIT_M1) fetch_err <= 1'b1;
                if (wait_cnt != 8'hFF)    wait_cnt  <= wait_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_lc3_fetch_stage.sv
module tb_lc3_fetch_stage;

    localparam logic [15:0] RST_PC = 16'h3000;
    localparam int          LIMIT  = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_fetch = 1'b0;
    logic        enable_updatePC = 1'b0;
    logic [15:0] taddr = 16'h0000;
    logic        br_taken = 1'b0;
    logic        imem_rdy = 1'b0;
    logic [15:0] imem_dout = 16'h0000;
    logic [15:0] pc, npc, ir;
    logic        instrmem_rd, ir_valid, fetch_busy, fetch_err;

    lc3_fetch_stage #(.RESET_PC(RST_PC), .WAIT_LIMIT(LIMIT)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .taddr           (taddr),
        .br_taken        (br_taken),
        .imem_rdy        (imem_rdy),
        .imem_dout       (imem_dout),
        .pc              (pc),
        .npc             (npc),
        .instrmem_rd     (instrmem_rd),
        .ir              (ir),
        .ir_valid        (ir_valid),
        .fetch_busy      (fetch_busy),
        .fetch_err       (fetch_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit armed = 0;

    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] data;
        int          at_cyc;
    } exp_t;
    exp_t sb[$];

    // Reference model: a memory request is either absent, live (address
    // still valid) or orphaned by a PC change; wait_cycles counts unanswered
    // cycles of an outstanding request.
    typedef enum int {REQ_NONE, REQ_LIVE, REQ_ORPHAN} req_t;
    req_t        m_req = REQ_NONE;
    int          m_wait = 0;
    int          m_pc = 0;
    logic [15:0] m_ir = 16'h0;
    bit          m_err = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ir_valid pulse must match the oldest predicted word,
    // arriving on the predicted cycle.
    always @(negedge clock) begin
        if (ir_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL ir_valid_unexpected: got pulse with ir=%h expected none (cycle %0d)", ir, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (ir !== e.data || cyc != e.at_cyc) begin
                    fails++;
                    $display("FAIL ir_word: got %h at cycle %0d expected %h at cycle %0d",
                             ir, cyc, e.data, e.at_cyc);
                end
            end
        end
    end

    // One clock cycle: drive inputs, check outputs against the model
    // mid-cycle, then advance the model across the rising edge.
    task automatic step(input logic rs, input logic ef, input logic upd, input logic br,
                        input logic rdy, input logic [15:0] ta, input logic [15:0] dout);
        bit exp_rd, exp_busy, acc;
        reset = rs; enable_fetch = ef; enable_updatePC = upd; br_taken = br;
        imem_rdy = rdy; taddr = ta; imem_dout = dout;
        @(negedge clock);
        exp_rd   = (m_req == REQ_LIVE) || (m_req == REQ_NONE && ef);
        exp_busy = (m_req != REQ_NONE);
        if (armed) begin
            chk("pc", pc, 16'(m_pc));
            chk("npc", npc, 16'((m_pc + 1) % 65536));
            chk("instrmem_rd", 16'(instrmem_rd), 16'(exp_rd));
            chk("fetch_busy", 16'(fetch_busy), 16'(exp_busy));
            chk("ir", ir, m_ir);
            chk("fetch_err", 16'(fetch_err), 16'(m_err));
        end
        if (!rs) begin
            m_req = REQ_NONE; m_wait = 0; m_pc = RST_PC; m_ir = 16'h0; m_err = 0;
            armed = 1;
        end else begin
            acc = rdy && ((m_req == REQ_NONE && ef) || m_req == REQ_LIVE);
            if (acc) begin
                sb.push_back('{data: dout, at_cyc: cyc + 1});
                m_ir = dout;
            end
            if (m_req != REQ_NONE && !rdy) begin
                m_wait++;
                if (m_wait >= LIMIT) m_err = 1;
            end
            case (m_req)
                REQ_NONE:   if (ef && !rdy) begin m_req = REQ_LIVE; m_wait = 0; end
                REQ_LIVE:   if (rdy) m_req = REQ_NONE; else if (upd) m_req = REQ_ORPHAN;
                REQ_ORPHAN: if (rdy) m_req = REQ_NONE;
                default:    m_req = REQ_NONE;
            endcase
            if (upd) m_pc = br ? int'(ta) : (m_pc + 1) % 65536;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        chk("reset_pc", pc, 16'h3000);
        chk("reset_npc", npc, 16'h3001);
        chk("reset_ir", ir, 16'h0000);
        chk("reset_rd", 16'(instrmem_rd), 16'h0);

        // Zero-wait fetch
        step(1, 1, 0, 0, 1, 16'h0, 16'h1234);
        chk("zw_ir_valid", 16'(ir_valid), 16'h1);
        chk("zw_ir", ir, 16'h1234);
        idle(1);
        chk("zw_pulse_end", 16'(ir_valid), 16'h0);

        // PC updates: walk to 3005, branch, sequential, wrap
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 16'h0, 16'h0);
        chk("pc_3005", pc, 16'h3005);
        step(1, 0, 1, 1, 0, 16'h4000, 16'h0);
        chk("pc_branch", pc, 16'h4000);
        step(1, 0, 0, 1, 0, 16'h7777, 16'h0);
        chk("pc_hold", pc, 16'h4000);
        step(1, 0, 1, 1, 0, 16'h3005, 16'h0);
        step(1, 0, 1, 0, 0, 16'h4000, 16'h0);
        chk("pc_seq", pc, 16'h3006);
        step(1, 0, 1, 1, 0, 16'hFFFF, 16'h0);
        step(1, 0, 1, 0, 0, 16'h0, 16'h0);
        chk("pc_wrap", pc, 16'h0000);

        // Three wait states; enable_fetch dropped mid-request
        step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0, 16'hABCD);
        chk("ws_ir", ir, 16'hABCD);
        idle(1);

        // Redirect during WAIT: response dropped, next read at 5000
        step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        step(1, 0, 1, 1, 0, 16'h5000, 16'h0);
        step(1, 0, 0, 0, 0, 16'h0, 16'h0);
        step(1, 1, 0, 0, 1, 16'h0, 16'hDEAD);
        chk("flush_ir_kept", ir, 16'hABCD);
        chk("flush_no_valid", 16'(ir_valid), 16'h0);
        chk("redirect_pc", pc, 16'h5000);
        step(1, 1, 0, 0, 1, 16'h0, 16'h0F0F);
        idle(1);

        // Watchdog: withhold imem_rdy past the limit, then answer late
        for (int i = 0; i < LIMIT + 2; i++) step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        chk("wd_err", 16'(fetch_err), 16'h1);
        step(1, 0, 0, 0, 1, 16'h0, 16'h2222);
        idle(2);
        chk("wd_sticky", 16'(fetch_err), 16'h1);
        step(0, 0, 0, 0, 0, 16'h0, 16'h0);
        chk("wd_cleared", 16'(fetch_err), 16'h0);

        // Reset in the middle of WAIT, then a stray response
        step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        step(1, 1, 0, 0, 0, 16'h0, 16'h0);
        step(0, 1, 0, 0, 1, 16'h0, 16'h9999);
        step(1, 0, 0, 0, 1, 16'h0, 16'h8888);
        chk("rst_wait_ir", ir, 16'h0000);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 16'($urandom), 16'($urandom));
        end
        idle(3);

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL ir_valid_missing: got %0d words never delivered, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lc3_fetch_stage.md
Name: lc3_fetch_stage

Overview:
- Fetch stage of the LC3 pipeline; directly consumes the fetch_in control bundle: enable_fetch, enable_updatePC, taddr, br_taken.
- Owns the PC and next-PC, and drives the instruction-memory read strobe.
- Runs a handshake with the instruction memory, which may insert wait states.
- Latches the returned word into an IR register for decode; discards stale data after a PC redirect.

Parameters:
- RESET_PC, 16'h3000, PC value loaded on reset.
- WAIT_LIMIT, 15, max WAIT cycles without imem_rdy before fetch_err sets; range 1..255.

Ports:
- clock  in  1  stage clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- enable_fetch  in  1  controller permits a new instruction read
- enable_updatePC  in  1  controller permits PC update this cycle
- taddr  in  16  branch/jump target address
- br_taken  in  1  select taddr instead of npc on PC update
- imem_rdy  in  1  instruction memory returns imem_dout this cycle
- imem_dout  in  16  instruction word from memory
- pc  out  16  current PC; also the instruction-memory address
- npc  out  16  pc + 1, combinational, modulo 2^16
- instrmem_rd  out  1  read strobe to instruction memory
- ir  out  16  last accepted instruction word
- ir_valid  out  1  one-cycle pulse: ir updated on this edge
- fetch_busy  out  1  high in WAIT or FLUSH
- fetch_err  out  1  sticky; memory failed to respond within WAIT_LIMIT

Behaviour:
- Reset (reset==0 at an edge): pc=RESET_PC, ir=16'h0000, ir_valid=0, fetch_err=0, state=IDLE, wait counter=0. Outputs follow combinationally: instrmem_rd=0, fetch_busy=0, npc=RESET_PC+1. Reset wins over every other input, including a request in progress; the returning memory data is ignored.
- PC update, independent of FSM state: on an edge with enable_updatePC=1, pc <= br_taken ? taddr : npc. When enable_updatePC=0, pc holds. br_taken is ignored when enable_updatePC=0. 16'hFFFF+1 wraps to 16'h0000.
- FSM states: IDLE, WAIT, FLUSH.
- IDLE:
  - instrmem_rd = enable_fetch (combinational).
  - enable_fetch=1 and imem_rdy=1 (zero-wait memory): ir<=imem_dout, ir_valid=1 next cycle, stay IDLE.
  - enable_fetch=1 and imem_rdy=0: go WAIT, counter cleared.
  - imem_rdy while not reading: ignored.
- WAIT:
  - instrmem_rd=1; counter increments each cycle.
  - imem_rdy=1: ir<=imem_dout, ir_valid pulse, go IDLE. This holds even if enable_updatePC is high in the same cycle, because the data belongs to the old pc.
  - enable_updatePC=1 with imem_rdy=0: the address is now stale; go FLUSH.
  - counter reaches WAIT_LIMIT without imem_rdy: fetch_err<=1 (sticky until reset); stay WAIT.
- FLUSH:
  - instrmem_rd=0; enable_fetch ignored.
  - Next imem_rdy: data discarded, no ir_valid, go IDLE.
  - Further enable_updatePC: pc updates, stay FLUSH.
  - WAIT_LIMIT also applies in FLUSH; counter is not cleared on the WAIT->FLUSH transition.
- enable_fetch deasserted in WAIT: the request still completes; the strobe is held until imem_rdy.
- Latency: the IR is valid 1 cycle after imem_rdy, or 1 cycle after the strobe for zero-wait memory.

Decomposition:
- Shared package lc3_fetch_pkg:
  - typedef enum logic [1:0] fetch_state_t {IDLE, WAIT, FLUSH}
  - localparam LC3_RESET_PC = 16'h3000
  - typedef logic [15:0] lc3_word_t
- One sub-module, lc3_pc_unit: PC register, npc adder and taddr/npc mux, taking reset, enable_updatePC, br_taken, taddr.
- The FSM, IR latch and watchdog stay in the top module.

Test Plan:
- Reset release, enable_fetch=1, imem_rdy=1, imem_dout=16'h1234 -> instrmem_rd=1 at pc=16'h3000, ir=16'h1234, ir_valid pulse 1 cycle later, npc=16'h3001.
- pc=16'h3005, enable_updatePC=1, br_taken=1, taddr=16'h4000 -> pc=16'h4000. Same with br_taken=0 -> pc=16'h3006. Sequential update from pc=16'hFFFF -> 16'h0000.
- Fetch with imem_rdy delayed 3 cycles, dout=16'hABCD -> fetch_busy high 3 cycles, instrmem_rd held, ir=16'hABCD, one ir_valid pulse.
- In WAIT, br_taken redirect to 16'h5000 at cycle 1; imem_rdy at cycle 3 with 16'hDEAD -> no ir_valid, ir unchanged, state IDLE; the next fetch reads pc=16'h5000.
- imem_rdy withheld for WAIT_LIMIT cycles -> fetch_err=1 and stays 1 after a late imem_rdy; clears only on reset=0.
- reset=0 during WAIT -> next cycle: pc=RESET_PC, state IDLE, ir=0, fetch_err=0; a subsequent stray imem_rdy produces no ir_valid.
